// File: rtl/ula_despacho_if.sv
// ula_despacho_if: request/response handshakes, ALU drive/return and
// status bundle shared between the dispatcher and its neighbours.
interface ula_despacho_if #(
  parameter int IMM_W = 16,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [IMM_W-1:0] req_imm;
  logic             req_use_imm;

  logic [3:0]       controle;
  logic [31:0]      DA;
  logic [31:0]      DB;
  logic [31:0]      ULAresult;
  logic             zero;
  logic             negativo;
  logic             overflow;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic             resp_zero;
  logic             resp_neg;
  logic             resp_ovf;
  logic             resp_taken;
  logic             resp_illegal;

  logic [CNT_W-1:0] op_count;
  logic             ovf_sticky;
  logic             ovf_clr;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  req_imm, req_use_imm,
    input  ULAresult, zero, negativo, overflow,
    input  resp_ready, ovf_clr,
    output req_ready, controle, DA, DB,
    output resp_valid, resp_result, resp_zero,
    output resp_neg, resp_ovf, resp_taken,
    output resp_illegal, op_count, ovf_sticky
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output req_imm, req_use_imm,
    output ULAresult, zero, negativo, overflow,
    output resp_ready, ovf_clr,
    input  req_ready, controle, DA, DB,
    input  resp_valid, resp_result, resp_zero,
    input  resp_neg, resp_ovf, resp_taken,
    input  resp_illegal, op_count, ovf_sticky
  );
endinterface

// File: rtl/ula_despacho.sv
// ula_despacho: one-at-a-time ALU dispatcher (IDLE -> EXEC -> RESP).
// Define ULA_DESPACHO_OVF_TRAP_EN to enable the sticky overflow trap.
module ula_despacho #(
  parameter int CNT_W = 16,
  parameter int IMM_W = 16
) (
  input logic            clock,
  input logic            reset,
  ula_despacho_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           r_state;
  logic [3:0]       r_ctrl;
  logic [31:0]      r_da;
  logic [31:0]      r_db;
  logic [31:0]      r_res;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic             r_taken;
  logic             r_illegal;
  logic             r_valid;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic signed [IMM_W-1:0] w_imm;
  logic [31:0]      w_b;
  logic             w_ready;
  logic             w_acc;
  logic             w_hs;
  logic             w_illegal;
  logic             w_taken;
  logic             w_set;
  logic             w_clr;

  assign w_imm     = bus.req_imm;
  assign w_b       = bus.req_use_imm ? 32'(w_imm)
                                     : bus.req_b;
  assign w_illegal = &bus.req_op[3:1];
  assign w_ready   = (r_state == IDLE) & ~r_sticky
                   & ~reset;
  assign w_acc     = bus.req_valid & w_ready;
  assign w_hs      = r_valid & bus.resp_ready;
  assign w_clr     = bus.ovf_clr;

`ifdef ULA_DESPACHO_OVF_TRAP_EN
  assign w_set = (r_state == EXEC) & bus.overflow;
`else
  // Without the trap nothing ever sets the flag, so it stays 0.
  assign w_set = 1'b0;
`endif

  always_comb begin
    w_taken = 1'b0;
    unique case (1'b1)
      r_ctrl == 4'd7: w_taken = bus.zero;
      r_ctrl == 4'd8: w_taken = ~bus.zero;
      r_ctrl == 4'd9: w_taken = bus.negativo;
      default:        w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ctrl    <= '0;
      r_da      <= '0;
      r_db      <= '0;
      r_res     <= '0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
      r_sticky  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sticky <= (r_sticky & ~w_clr) | w_set;
      unique case (r_state)
        IDLE: begin
          if (w_acc && w_illegal) begin
            r_res     <= '0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= RESP;
          end else if (w_acc) begin
            r_ctrl  <= bus.req_op;
            r_da    <= bus.req_a;
            r_db    <= w_b;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res     <= bus.ULAresult;
          r_zero    <= bus.zero;
          r_neg     <= bus.negativo;
          r_ovf     <= bus.overflow;
          r_taken   <= w_taken;
          r_illegal <= 1'b0;
          r_valid   <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.controle     = r_ctrl;
  assign bus.DA           = r_da;
  assign bus.DB           = r_db;
  assign bus.resp_valid   = r_valid;
  assign bus.resp_result  = r_res;
  assign bus.resp_zero    = r_zero;
  assign bus.resp_neg     = r_neg;
  assign bus.resp_ovf     = r_ovf;
  assign bus.resp_taken   = r_taken;
  assign bus.resp_illegal = r_illegal;
  assign bus.op_count     = r_cnt;
  assign bus.ovf_sticky   = r_sticky;
endmodule

// File: tb/tb_ula_despacho.sv
// tb_ula_despacho: directed literal cases plus randomized traffic checked
// against a transaction-level model; bench also plays the external ALU.
module tb_ula_despacho;
  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        o;
  } alu_t;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        o;
    logic        t;
    logic        i;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  ula_despacho_if #(.IMM_W(16), .CNT_W(16)) bus ();

  ula_despacho #(.CNT_W(16), .IMM_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic alu_t alu(input logic [3:0] op,
                               input logic [31:0] a,
                               input logic [31:0] b);
    alu_t t;
    logic [32:0] s;
    t = '0;
    s = '0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        t.r = s[31:0];
        t.o = s[32];
      end
      4'd1: begin
        t.r = a - b;
        t.o = (a < b);
      end
      4'd2: t.r = a & b;
      4'd3: t.r = a | b;
      4'd4: t.r = ~a;
      4'd5: t.r = a << b[4:0];
      4'd6: t.r = a >> b[4:0];
      4'd7, 4'd8: t.r = a - b;
      4'd9: t.r = a;
      4'd10: t.r = {31'd0, $signed(a) < $signed(b)};
      4'd11: t.r = {31'd0, $signed(a) > $signed(b)};
      4'd12: t.r = a * b;
      4'd13: t.r = (b == 32'd0) ? 32'd0 : a / b;
      default: t.r = 32'd0;
    endcase
    t.z = (t.r == 32'd0);
    t.n = t.r[31];
    return t;
  endfunction

  alu_t w_alu;
  assign w_alu         = alu(bus.controle, bus.DA, bus.DB);
  assign bus.ULAresult = w_alu.r;
  assign bus.zero      = w_alu.z;
  assign bus.negativo  = w_alu.n;
  assign bus.overflow  = w_alu.o;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: one outstanding op, visible from edge m_due on.
  int          e = 0;
  int          m_due = 0;
  logic        m_pend = 1'b0;
  logic        m_sticky = 1'b0;
  logic [15:0] m_count = '0;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_da = '0;
  logic [31:0] m_db = '0;
  resp_t       m_exp = '0;

  always @(posedge clock) begin
    logic hs, cap, acc, ill;
    logic [31:0] beff;
    alu_t t;
    hs  = m_pend && (e >= m_due) && bus.resp_ready;
    cap = m_pend && !m_exp.i && (e + 1 == m_due);
    acc = !m_pend && !m_sticky && bus.req_valid;
    e++;
    if (reset) begin
      m_pend = 1'b0; m_sticky = 1'b0; m_count = '0;
      m_ctrl = '0; m_da = '0; m_db = '0;
    end else begin
      if (hs) begin
        m_pend = 1'b0;
        m_count++;
      end
`ifdef ULA_DESPACHO_OVF_TRAP_EN
      m_sticky = (m_sticky & ~bus.ovf_clr) | (cap & m_exp.o);
`else
      m_sticky = 1'b0;
`endif
      if (acc) begin
        ill  = (bus.req_op >= 4'd14);
        beff = bus.req_use_imm
             ? {{16{bus.req_imm[15]}}, bus.req_imm} : bus.req_b;
        m_pend = 1'b1;
        if (ill) begin
          m_exp = '0;
          m_exp.i = 1'b1;
          m_due = e;
        end else begin
          t = alu(bus.req_op, bus.req_a, beff);
          m_exp.r = t.r; m_exp.z = t.z;
          m_exp.n = t.n; m_exp.o = t.o; m_exp.i = 1'b0;
          m_exp.t = (bus.req_op == 4'd7) ? t.z :
                    (bus.req_op == 4'd8) ? ~t.z :
                    (bus.req_op == 4'd9) ? t.n : 1'b0;
          m_ctrl = bus.req_op; m_da = bus.req_a; m_db = beff;
          m_due = e + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic vis;
    if (chk_en) begin
      vis = m_pend && (e >= m_due);
      chk("cmp_req_ready", bus.req_ready,
          !m_pend && !m_sticky && !reset);
      chk("cmp_resp_valid", bus.resp_valid, vis);
      chk("cmp_op_count", bus.op_count, m_count);
      chk("cmp_ovf_sticky", bus.ovf_sticky, m_sticky);
      chk("cmp_controle", bus.controle, m_ctrl);
      chk("cmp_DA", bus.DA, m_da);
      chk("cmp_DB", bus.DB, m_db);
      chk("cmp_both_hi", bus.req_ready & bus.resp_valid, 0);
      if (vis) begin
        chk("cmp_result", bus.resp_result, m_exp.r);
        chk("cmp_flags",
            {bus.resp_zero, bus.resp_neg, bus.resp_ovf,
             bus.resp_taken, bus.resp_illegal},
            {m_exp.z, m_exp.n, m_exp.o, m_exp.t, m_exp.i});
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm,
                       input logic ui);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("issue_ready", bus.req_ready, 1);
    bus.req_op = op; bus.req_a = a; bus.req_b = b;
    bus.req_imm = imm; bus.req_use_imm = ui;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid", bus.resp_valid, 1);
  endtask

  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = '0; bus.req_a = '0;
    bus.req_b = '0; bus.req_imm = '0; bus.req_use_imm = 0;
    bus.resp_ready = 0; bus.ovf_clr = 0;
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_ctrl", bus.controle, 0);
    chk("rst_DA", bus.DA, 0);
    chk("rst_DB", bus.DB, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_zero, bus.resp_neg,
        bus.resp_ovf, bus.resp_taken, bus.resp_illegal}, 0);
    chk("rst_result", bus.resp_result, 0);
    chk("rst_count", bus.op_count, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", bus.req_ready, 1);

    issue(4'd0, 32'd5, 32'd7, 16'd0, 1'b0);
    chk("add_exec_valid", bus.resp_valid, 0);
    tick();
    chk("add_lat_valid", bus.resp_valid, 1);
    chk("add_result", bus.resp_result, 32'd12);
    chk("add_zero_ovf", {bus.resp_zero, bus.resp_ovf}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", bus.resp_result, 32'd12);
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_count", bus.op_count, 0);
    end
    finish_resp();
    chk("add_count", bus.op_count, 1);

    issue(4'd7, 32'h1234, 32'h1234, 16'd0, 1'b0);
    wait_valid();
    chk("beq_taken_zero", {bus.resp_taken, bus.resp_zero}, 2'b11);
    finish_resp();
    issue(4'd8, 32'h1234, 32'h1234, 16'd0, 1'b0);
    wait_valid();
    chk("bneq_taken", bus.resp_taken, 0);
    finish_resp();

    issue(4'd15, 32'd3, 32'd4, 16'd0, 1'b0);
    chk("ill_valid", bus.resp_valid, 1);
    chk("ill_flag", bus.resp_illegal, 1);
    chk("ill_result", bus.resp_result, 0);
    chk("ill_ctrl", bus.controle, 4'd8);
    finish_resp();
    chk("ill_count", bus.op_count, 4);

    issue(4'd0, 32'd10, 32'd99, 16'hFFFE, 1'b1);
    chk("imm_DB", bus.DB, 32'hFFFF_FFFE);
    wait_valid();
    chk("imm_result", bus.resp_result, 32'd8);
    finish_resp();

    issue(4'd0, 32'd1, 32'd2, 16'd0, 1'b0);
    reset = 1'b1;
    chk("rst_cyc_ready", bus.req_ready, 0);
    tick();
    reset = 1'b0;
    chk("rst_exec_valid", bus.resp_valid, 0);
    chk("rst_exec_count", bus.op_count, 0);
    tick();
    chk("rst_exec_ready", bus.req_ready, 1);
    chk("rst_exec_novalid", bus.resp_valid, 0);

    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0);
    wait_valid();
    chk("ovf_flag", bus.resp_ovf, 1);
    chk("ovf_result", bus.resp_result, 0);
    finish_resp();
`ifdef ULA_DESPACHO_OVF_TRAP_EN
    chk("trap_sticky", bus.ovf_sticky, 1);
    for (int i = 0; i < 3; i++) begin
      chk("trap_hold", bus.req_ready, 0);
      tick();
    end
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("trap_clr_ready", bus.req_ready, 1);
`else
    chk("notrap_ready", bus.req_ready, 1);
    chk("notrap_sticky", bus.ovf_sticky, 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = ($urandom % 2) == 0;
      bus.req_op = 4'($urandom % 16);
      bus.req_a = ($urandom % 4 == 0) ? $urandom % 8 : $urandom;
      bus.req_b = ($urandom % 4 == 0) ? bus.req_a : $urandom;
      bus.req_imm = 16'($urandom);
      bus.req_use_imm = ($urandom % 4) == 0;
      bus.resp_ready = ($urandom % 3) != 0;
      bus.ovf_clr = ($urandom % 8) == 0;
      reset = ($urandom % 300) == 0;
      tick();
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ula_despacho.md
ULA_DESPACHO -- requirements
Module: ula_despacho

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the completed-operation counter.
REQ-002 SHALL have parameter IMM_W, default 16, the immediate width; sign-extended to 32 bits.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_op  input  4  ALU operation code: 0 adc, 1 sub, 2 and, 3 or, 4 not, 5 shl, 6 shr, 7 beq, 8 bneq, 9 blz, 10 slt, 11 sgt, 12 mult, 13 div; 14/15 illegal.
REQ-008 req_a, req_b  input  32 each  operands.
REQ-009 req_imm  input  IMM_W  immediate; req_use_imm  input  1  selects sign-extended req_imm as B operand.
REQ-010 controle  output  4; DA, DB  output  32 each  registered drive to the ALU.
REQ-011 ULAresult  input  32; zero, negativo, overflow  input  1 each  ALU returns (combinational).
REQ-012 resp_valid  output  1; resp_ready  input  1  response handshake.
REQ-013 resp_result  output  32; resp_zero, resp_neg, resp_ovf, resp_taken, resp_illegal  output  1 each.
REQ-014 op_count  output  CNT_W  completed responses; ovf_sticky  output  1; ovf_clr  input  1.

Function
REQ-015 FSM states IDLE, EXEC, RESP; req_ready SHALL be 1 only in IDLE (and, with REQ-030, only while ovf_sticky=0).
REQ-016 IDLE: req_valid&req_ready at edge N latches op into controle, req_a into DA, B operand into DB; next state EXEC.
REQ-017 Illegal op (14/15) SHALL skip EXEC: go to RESP with resp_illegal=1, resp_result=0, all flags 0; controle/DA/DB unchanged.
REQ-018 EXEC lasts exactly one cycle; at its closing edge (N+1) ULAresult and flags are captured into resp_* registers; next state RESP.
REQ-019 resp_taken: op 7 -> zero; op 8 -> ~zero; op 9 -> negativo; all other ops 0.
REQ-020 RESP: resp_valid=1; all resp_* SHALL stay stable until resp_valid&resp_ready; then IDLE on that edge.
REQ-021 Latency: resp_valid first high in cycle following edge N+1 (N+1 for illegal ops at edge N).
REQ-022 op_count increments by 1 on every completed response handshake, including illegal; wraps at 2^CNT_W-1 to 0.
REQ-023 controle/DA/DB SHALL hold the last issued values outside EXEC; no combinational path req_* -> ALU outputs.
REQ-024 resp_valid asserted only in RESP; req_ready and resp_valid never both 1.

Reset
REQ-025 reset SHALL override all other inputs in the same edge: state IDLE.
REQ-026 Reset values: controle 0, DA 0, DB 0, resp_valid 0, resp_result 0, all resp_* flags 0, op_count 0, ovf_sticky 0.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation with no response and no op_count increment.
REQ-028 req_ready SHALL be 0 in the cycle reset is asserted, 1 in the first cycle after release.

Configuration
REQ-029 Macro ULA_DESPACHO_OVF_TRAP_EN selects the overflow trap.
REQ-030 Defined: ovf_sticky set at the capture edge when overflow=1; while set, req_ready=0; ovf_clr=1 clears it at the next edge; set and clear in the same edge -> set wins.
REQ-031 Not defined: ovf_sticky tied 0, ovf_clr ignored; overflow reported only via resp_ovf.

Verification
REQ-032 op 0, a=5, b=7, accept at edge N -> resp_valid after edge N+1, resp_result=12, resp_zero=0, resp_ovf=0, op_count=1 after handshake.
REQ-033 op 7, a=b=0x1234 -> resp_taken=1, resp_zero=1; op 8 same operands -> resp_taken=0.
REQ-034 op 0, a=0xFFFFFFFF, b=1 -> resp_ovf=1, resp_result=0; with macro, req_ready stays 0 until ovf_clr pulse, then 1.
REQ-035 resp_ready held 0 for 3 cycles in RESP -> resp_* stable, req_ready=0 throughout, single op_count increment.
REQ-036 op 15 -> resp_illegal=1 one cycle after accept, controle unchanged; reset asserted in EXEC -> IDLE, no response, op_count unchanged.
REQ-037 req_use_imm=1, op 0, a=10, imm=0xFFFE -> DB=0xFFFFFFFE during EXEC, resp_result=8.
